// File: rtl/sd_cmd_controller.sv
// SD CMD-line sequencer: sends a 48-bit command frame with CRC7, turns the PAD
// around, hunts for the card start bit and captures a 48- or 136-bit response.
// Optional receive CRC7/end-bit checking is built when SD_RESP_CRC_CHECK_EN is defined.
module sd_cmd_controller #(
  parameter int TIMEOUT     = 64,
  parameter int TURN_CYCLES = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         cmd_start,
  input  logic [5:0]   cmd_index,
  input  logic [31:0]  cmd_arg,
  input  logic [1:0]   resp_type,
  output logic         busy,
  output logic         done,
  output logic         timeout_err,
  output logic         crc_err,
  output logic [135:0] resp_data,
  output logic         pad_enable,
  output logic         pad_oe,
  output logic         pad_dout,
  input  logic         pad_din
);

  localparam int MAXW = (TIMEOUT > TURN_CYCLES) ? TIMEOUT : TURN_CYCLES;
  localparam int WW   = $clog2(MAXW + 1);

  typedef enum logic [3:0] {
    IDLE, PREP, SEND, FLUSH, TURN, WAIT_START, RECV, CHECK, DONE
  } state_t;

  state_t         state_q, state_d;
  logic [39:0]    tx_shift;
  logic [6:0]     tx_crc;
  logic [7:0]     bit_cnt;
  logic [WW-1:0]  wait_cnt;
  logic [1:0]     type_q;
  logic           send_bit;
  logic [7:0]     rx_last;

  // One CRC7 (x^7 + x^3 + 1) step, data bit entering MSB first
  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  // Frame bit on the line: header/argument, then the running CRC, then the end bit
  always_comb begin
    send_bit = 1'b1;
    if (bit_cnt >= 8'd8)
      send_bit = tx_shift[39];
    else if (bit_cnt != 8'd0)
      send_bit = tx_crc[bit_cnt[2:0] - 3'd1];
  end

  assign rx_last = (type_q == 2'b10) ? 8'd135 : 8'd47;

  // State register; an asynchronous reset abandons any transfer and releases the PAD
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode and PAD/handshake outputs decoded from the current state
  always_comb begin
    state_d    = state_q;
    busy       = 1'b1;
    done       = 1'b0;
    pad_enable = 1'b1;
    pad_oe     = 1'b0;
    pad_dout   = 1'b1;
    case (state_q)
      IDLE: begin
        busy       = 1'b0;
        pad_enable = 1'b0;
        if (cmd_start) state_d = PREP;
      end
      PREP: begin
        pad_oe  = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        pad_oe   = 1'b1;
        pad_dout = send_bit;
        if (bit_cnt == 8'd0) state_d = FLUSH;
      end
      FLUSH: begin
        pad_oe  = 1'b1;
        state_d = (type_q == 2'b00) ? DONE : TURN;
      end
      TURN: begin
        if (wait_cnt == WW'(TURN_CYCLES - 1)) state_d = WAIT_START;
      end
      WAIT_START: begin
        if (!pad_din)                              state_d = RECV;
        else if (wait_cnt == WW'(TIMEOUT - 1))     state_d = DONE;
      end
      RECV: begin
        if (bit_cnt == rx_last) state_d = CHECK;
      end
      CHECK: state_d = DONE;
      DONE: begin
        done       = 1'b1;
        pad_enable = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Command latch, transmit shifter with on-the-fly CRC, turnaround/timeout counting and response capture
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_shift    <= '0;
      tx_crc      <= '0;
      bit_cnt     <= '0;
      wait_cnt    <= '0;
      type_q      <= '0;
      resp_data   <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_start) begin
            tx_shift    <= {2'b01, cmd_index, cmd_arg};
            tx_crc      <= '0;
            bit_cnt     <= 8'd47;
            type_q      <= resp_type;
            resp_data   <= '0;
            timeout_err <= 1'b0;
          end
        end
        SEND: begin
          if (bit_cnt >= 8'd8) begin
            tx_crc   <= crc7_step(tx_crc, tx_shift[39]);
            tx_shift <= {tx_shift[38:0], 1'b0};
          end
          if (bit_cnt != 8'd0) bit_cnt <= bit_cnt - 8'd1;
        end
        FLUSH: wait_cnt <= '0;
        TURN: begin
          if (wait_cnt == WW'(TURN_CYCLES - 1)) wait_cnt <= '0;
          else                                  wait_cnt <= wait_cnt + WW'(1);
        end
        WAIT_START: begin
          if (!pad_din) begin
            resp_data <= {resp_data[134:0], 1'b0};
            bit_cnt   <= 8'd1;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
            if (wait_cnt == WW'(TIMEOUT - 1)) timeout_err <= 1'b1;
          end
        end
        RECV: begin
          resp_data <= {resp_data[134:0], pad_din};
          bit_cnt   <= bit_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef SD_RESP_CRC_CHECK_EN
  logic crc_err_q;

  // CRC7 over the 40 leading response bits, recomputed in one pass for the check cycle
  function automatic logic [6:0] crc7_over40(input logic [39:0] bits);
    logic [6:0] c;
    c = '0;
    for (int i = 39; i >= 0; i--) c = crc7_step(c, bits[i]);
    return c;
  endfunction

  // Response CRC/end-bit verdict for CRC-protected 48-bit responses, held until the next command
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      crc_err_q <= 1'b0;
    else if (state_q == IDLE && cmd_start)
      crc_err_q <= 1'b0;
    else if (state_q == CHECK && type_q == 2'b01)
      crc_err_q <= (crc7_over40(resp_data[47:8]) != resp_data[7:1]) || !resp_data[0];
  end

  assign crc_err = crc_err_q;
`else
  assign crc_err = 1'b0;
`endif

endmodule

// File: tb/tb_sd_cmd_controller.sv
// Directed bench for sd_cmd_controller: frame streams, turnaround, response capture,
// CRC/end-bit errors, start-bit timeout and reset abort.
module tb_sd_cmd_controller;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         cmd_start = 1'b0;
  logic [5:0]   cmd_index = '0;
  logic [31:0]  cmd_arg = '0;
  logic [1:0]   resp_type = '0;
  logic         busy, done, timeout_err, crc_err;
  logic [135:0] resp_data;
  logic         pad_enable, pad_oe, pad_dout;
  logic         pad_din = 1'b1;

  int checks = 0;
  int errors = 0;

  logic [47:0]  txStream;
  int           doneCycle;
  int           doneCount;
  logic         obsTimeout, obsCrc, oeFlush, oeDone, postBusy;
  logic [135:0] obsResp;

`ifdef SD_RESP_CRC_CHECK_EN
  localparam logic EXP_BAD_CRC = 1'b1;
`else
  localparam logic EXP_BAD_CRC = 1'b0;
`endif

  sd_cmd_controller dut (
    .clock(clock), .reset(reset), .cmd_start(cmd_start), .cmd_index(cmd_index),
    .cmd_arg(cmd_arg), .resp_type(resp_type), .busy(busy), .done(done),
    .timeout_err(timeout_err), .crc_err(crc_err), .resp_data(resp_data),
    .pad_enable(pad_enable), .pad_oe(pad_oe), .pad_dout(pad_dout), .pad_din(pad_din)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one command; cycle n is the cycle after the n-th edge counted from the accepting edge.
  // The card reply starts 'delay' cycles after pad_oe is seen low; rspLen 0 leaves pad_din idle high.
  task automatic applyStimulus(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] rt,
                               input logic [135:0] rsp, input int rspLen, input int delay,
                               input int injectCycle, input bit pokeAtDone);
    int respStart;
    respStart = -1;
    txStream  = '0;
    doneCycle = -1;
    doneCount = 0;
    oeFlush   = 1'b0;
    oeDone    = 1'b1;
    pad_din   = 1'b1;
    cmd_index = idx;
    cmd_arg   = arg;
    resp_type = rt;
    cmd_start = 1'b1;
    for (int c = 1; c <= 400 && doneCycle < 0; c++) begin
      @(posedge clock); #1;
      cmd_start = (c == injectCycle) ? 1'b1 : 1'b0;
      cmd_index = ~idx;
      cmd_arg   = ~arg;
      if (c >= 2 && c <= 49) txStream = {txStream[46:0], pad_dout};
      if (c == 50) oeFlush = pad_oe;
      if (c == 51) oeDone = pad_oe;
      if (respStart < 0 && busy && !pad_oe && c > 1) respStart = c + delay;
      pad_din = 1'b1;
      if (rspLen > 0 && respStart >= 0 && c >= respStart && c < respStart + rspLen)
        pad_din = rsp[rspLen - 1 - (c - respStart)];
      if (done) begin
        doneCount++;
        doneCycle  = c;
        obsTimeout = timeout_err;
        obsCrc     = crc_err;
        obsResp    = resp_data;
        if (pokeAtDone) cmd_start = 1'b1;
      end
    end
    @(posedge clock); #1;
    cmd_start = 1'b0;
    pad_din   = 1'b1;
    postBusy  = busy;
    if (done) doneCount++;
    repeat (3) @(posedge clock);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_timeout", timeout_err, 0);
    checkOutput("rst_crc", crc_err, 0);
    checkOutput("rst_pad_enable", pad_enable, 0);
    checkOutput("rst_pad_oe", pad_oe, 0);
    checkOutput("rst_pad_dout", pad_dout, 1);
    checkOutput("rst_resp", resp_data, 0);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    $display("[TB] CMD0, no response, cmd_start poked at done");
    applyStimulus(6'd0, 32'h0, 2'b00, '0, 0, 0, 0, 1'b1);
    checkOutput("cmd0_stream", txStream, 48'h400000000095);
    checkOutput("cmd0_done_cycle", doneCycle, 51);
    checkOutput("cmd0_done_count", doneCount, 1);
    checkOutput("cmd0_timeout", obsTimeout, 0);
    checkOutput("cmd0_crc", obsCrc, 0);
    checkOutput("cmd0_start_at_done_ignored", postBusy, 0);

    $display("[TB] CMD17, second cmd_start while busy");
    applyStimulus(6'd17, 32'h0, 2'b00, '0, 0, 0, 20, 1'b0);
    checkOutput("cmd17_stream", txStream, 48'h510000000055);
    checkOutput("cmd17_done_count", doneCount, 1);
    checkOutput("cmd17_oe_flush", oeFlush, 1);
    checkOutput("cmd17_oe_after_flush", oeDone, 0);
    checkOutput("cmd17_busy_after", postBusy, 0);

    $display("[TB] CMD8 with R7 reply");
    applyStimulus(6'd8, 32'h1AA, 2'b01, 136'h08000001AA13, 48, 5, 0, 1'b0);
    checkOutput("cmd8_stream", txStream, 48'h48000001AA87);
    checkOutput("cmd8_resp", obsResp, 136'h08000001AA13);
    checkOutput("cmd8_crc", obsCrc, 0);
    checkOutput("cmd8_timeout", obsTimeout, 0);

    $display("[TB] CMD8 with corrupted reply");
    applyStimulus(6'd8, 32'h1AA, 2'b01, 136'h08000001AA12, 48, 5, 0, 1'b0);
    checkOutput("bad_resp", obsResp, 136'h08000001AA12);
    checkOutput("bad_crc", obsCrc, EXP_BAD_CRC);
    checkOutput("bad_timeout", obsTimeout, 0);

    $display("[TB] no start bit");
    applyStimulus(6'd8, 32'h1AA, 2'b01, '0, 0, 0, 0, 1'b0);
    checkOutput("to_done_cycle", doneCycle, 117);
    checkOutput("to_timeout", obsTimeout, 1);
    checkOutput("to_resp", obsResp, 0);
    checkOutput("to_crc", obsCrc, 0);

    $display("[TB] R3 start bit on last wait cycle");
    applyStimulus(6'd41, 32'h00FF8000, 2'b11, 136'h3F80FF800000, 48, 65, 0, 1'b0);
    checkOutput("last_resp", obsResp, 136'h3F80FF800000);
    checkOutput("last_timeout", obsTimeout, 0);
    checkOutput("last_crc", obsCrc, 0);

    $display("[TB] R2 136-bit reply");
    applyStimulus(6'd2, 32'h0, 2'b10, 136'h3F0123456789ABCDEF0011223344556677, 136, 3, 0, 1'b0);
    checkOutput("r2_resp", obsResp, 136'h3F0123456789ABCDEF0011223344556677);
    checkOutput("r2_crc", obsCrc, 0);
    checkOutput("r2_timeout", obsTimeout, 0);

    $display("[TB] reset mid-send");
    cmd_index = 6'd0;
    cmd_arg   = 32'h0;
    resp_type = 2'b00;
    cmd_start = 1'b1;
    @(posedge clock); #1;
    cmd_start = 1'b0;
    repeat (28) @(posedge clock);
    #1;
    checkOutput("mid_pad_oe_before", pad_oe, 1);
    reset = 1'b0;
    #1;
    checkOutput("mid_busy", busy, 0);
    checkOutput("mid_done", done, 0);
    checkOutput("mid_pad_enable", pad_enable, 0);
    checkOutput("mid_pad_oe", pad_oe, 0);
    checkOutput("mid_pad_dout", pad_dout, 1);
    checkOutput("mid_resp", resp_data, 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    applyStimulus(6'd0, 32'h0, 2'b00, '0, 0, 0, 0, 1'b0);
    checkOutput("post_rst_stream", txStream, 48'h400000000095);
    checkOutput("post_rst_done_cycle", doneCycle, 51);
    checkOutput("post_rst_done_count", doneCount, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
